// File: rtl/mdu_issue.sv
// rtl/mdu_issue.sv - issue/writeback sequencer in front of the multiply/divide unit
module mdu_issue #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_rs1,
  input  logic [31:0] io_req_rs2,
  input  logic [2:0]  io_req_op,
  input  logic [4:0]  io_req_rd,
  input  logic        io_flush,
  output logic [31:0] io_mdu_rs1,
  output logic [31:0] io_mdu_rs2,
  output logic [2:0]  io_mdu_op,
  output logic        io_mdu_valid,
  input  logic        io_mdu_ready,
  input  logic [31:0] io_mdu_rd,
  output logic        io_wb_valid,
  input  logic        io_wb_ready,
  output logic [4:0]  io_wb_rd,
  output logic [31:0] io_wb_data,
  output logic        io_busy,
  output logic        io_timeout
);

  // Counter only needs to reach TIMEOUT_CYCLES-1: that is the cycle the timeout fires in.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WB     = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rs1_q;
  logic [31:0]   rs2_q;
  logic [2:0]    op_q;
  logic [4:0]    rd_q;
  logic [31:0]   wb_data_q;
  logic          timeout_q;

  logic          accept;
  logic          cnt_at_last;

  assign accept      = io_req_valid && io_req_ready;
  assign cnt_at_last = (cnt_q == CNT_LAST);

  // Handshake outputs decoded from the registered state; flush gates the
  // request and launch strobes in the same cycle so nothing escapes a kill.
  assign io_req_ready = (state_q == S_IDLE) && !io_flush;
  assign io_mdu_valid = (state_q == S_LAUNCH) && !io_flush;
  assign io_wb_valid  = (state_q == S_WB);
  assign io_busy      = (state_q != S_IDLE);
  assign io_mdu_rs1   = rs1_q;
  assign io_mdu_rs2   = rs2_q;
  assign io_mdu_op    = op_q;
  assign io_wb_rd     = rd_q;
  assign io_wb_data   = wb_data_q;
  assign io_timeout   = timeout_q;

  // Sequencer: captures the request, launches the MDU, tracks the
  // variable-latency result and holds it until writeback takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rs1_q <= io_req_rs1;
            rs2_q <= io_req_rs2;
            op_q  <= io_req_op;
            rd_q  <= io_req_rd;
            cnt_q <= '0;
            // A write to x0 has no architectural effect, so it is retired on accept.
            state_q <= (io_req_rd == 5'd0) ? S_IDLE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= io_flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (io_mdu_ready) begin
            if (!io_flush) begin
              wb_data_q <= io_mdu_rd;
              state_q   <= S_WB;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (cnt_at_last) begin
            // Abandoning wins over a flush: the MDU is considered hung either way.
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // The MDU cannot be aborted, so a killed request must still absorb its result.
            if (io_flush) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (io_mdu_ready) begin
            state_q <= S_IDLE;
          end else if (cnt_at_last) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WB: begin
          if (io_flush || io_wb_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
